// File: rtl/rr_arbiter_if.sv
// Handshake bundle between N requesters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface rr_arbiter_if #(
    parameter int N  = 4,
    parameter int IW = 2
);
    logic [N-1:0]  req;
    logic          done;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [IW-1:0] grant_idx;
    logic          timeout;

    modport master (
        output req, done,
        input  grant, grant_valid, grant_idx, timeout
    );

    modport slave (
        input  req, done,
        output grant, grant_valid, grant_idx, timeout
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with grant held until done or owner request drop.
// Optional forced release after HOLD_MAX cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter #(
    parameter int N        = 4,
    parameter int IW       = 2,
    parameter int HOLD_MAX = 16
) (
    input  logic         clk,
    input  logic         rst,
    rr_arbiter_if.slave  bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [IW:0]   NV        = (IW+1)'(N);
    localparam logic [IW-1:0] LAST_INIT = IW'(N-1);

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic            gv_q, gv_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   last_q, last_d;

    logic [IW-1:0]   last_p1;
    logic [2*N-1:0]  req_rot;
    logic [IW-1:0]   off;
    logic [IW:0]     sum;
    logic [IW-1:0]   pick_idx;
    logic [N-1:0]    pick_oh;
    logic            found;
    logic            rel;

    // Rotate the request vector so the search always starts at bit 0,
    // then map the winning offset back to an absolute index modulo N.
    always_comb begin
        last_p1 = (last_q == LAST_INIT) ? '0 : last_q + 1'b1;
        req_rot = {bus.req, bus.req} >> last_p1;
        off     = '0;
        found   = 1'b0;
        for (int j = N-1; j >= 0; j--) begin
            if (req_rot[j]) begin
                off   = IW'(j);
                found = 1'b1;
            end
        end
        sum = {1'b0, last_p1} + {1'b0, off};
        if (sum >= NV)
            sum = sum - NV;
        pick_idx = sum[IW-1:0];
        pick_oh  = {{(N-1){1'b0}}, 1'b1} << pick_idx;
    end

    assign rel = bus.done | ~bus.req[idx_q];

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(HOLD_MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;
    logic          limit;

    assign limit = (cnt_q == CW'(HOLD_MAX-1));
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gv_d    = gv_q;
        idx_d   = idx_q;
        last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick_oh;
                    gv_d    = 1'b1;
                    idx_d   = pick_idx;
                    state_d = BUSY;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                if (rel) begin
                    grant_d = '0;
                    gv_d    = 1'b0;
                    last_d  = idx_q;
                    state_d = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                // A genuine release on the limit cycle wins; no timeout pulse then.
                else if (limit) begin
                    grant_d = '0;
                    gv_d    = 1'b0;
                    last_d  = idx_q;
                    state_d = IDLE;
                    to_d    = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gv_q    <= 1'b0;
            idx_q   <= '0;
            last_q  <= LAST_INIT;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gv_q    <= gv_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign bus.timeout = to_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.grant       = grant_q;
    assign bus.grant_valid = gv_q;
    assign bus.grant_idx   = idx_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: reset, single grant, fairness, owner drop,
// reset mid-grant, and hold limit (timeout with ARB_TIMEOUT_EN, indefinite hold without).
module tb_rr_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    rr_arbiter_if #(.N(N), .IW(IW)) bus ();

    rr_arbiter #(.N(N), .IW(IW), .HOLD_MAX(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic check_grant(input string tag, input logic [3:0] g, input logic v, input logic [1:0] idx);
        check({tag, ".grant"}, 32'(bus.grant), 32'(g));
        check({tag, ".valid"}, 32'(bus.grant_valid), 32'(v));
        check({tag, ".idx"}, 32'(bus.grant_idx), 32'(idx));
    endtask

    logic [3:0] fair_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] fair_i [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        rst      = 1'b1;
        bus.req  = 4'b1111;
        bus.done = 1'b0;
        tick();
        tick();
        check_grant("reset", 4'b0000, 1'b0, 2'd0);
        check("reset.timeout", 32'(bus.timeout), 32'd0);

        // Single requester
        rst     = 1'b0;
        bus.req = 4'b0000;
        tick();
        bus.req = 4'b0001;
        tick();
        check_grant("single", 4'b0001, 1'b1, 2'd0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        bus.req  = 4'b0000;
        check_grant("single_rel", 4'b0000, 1'b0, 2'd0);
        tick();

        // Fairness from a fresh reset
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_grant($sformatf("fair%0d", k), fair_g[k], 1'b1, fair_i[k]);
            tick();
            check($sformatf("fair%0d.hold", k), 32'(bus.grant), 32'(fair_g[k]));
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
            check($sformatf("fair%0d.idle", k), 32'(bus.grant), 32'd0);
        end
        bus.req = 4'b0000;
        tick();

        // Owner drop without done (last = 0 here)
        bus.req = 4'b0100;
        tick();
        check_grant("drop.grant", 4'b0100, 1'b1, 2'd2);
        bus.req = 4'b0000;
        tick();
        check_grant("drop.rel", 4'b0000, 1'b0, 2'd2);
        bus.req = 4'b0011;
        tick();
        check_grant("drop.next", 4'b0001, 1'b1, 2'd0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        bus.req  = 4'b0000;
        tick();

        // Reset mid-grant
        bus.req = 4'b0100;
        tick();
        check("midrst.pre", 32'(bus.grant), 32'b0100);
        rst = 1'b1;
        tick();
        check_grant("midrst", 4'b0000, 1'b0, 2'd0);
        rst     = 1'b0;
        bus.req = 4'b0101;
        tick();
        check_grant("midrst.post", 4'b0001, 1'b1, 2'd0);
        bus.req = 4'b0000;
        tick();
        tick();

        // Hold limit (last = 0 here, so req=0011 grants 1 first; re-reset for the spec scenario)
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        bus.req = 4'b0011;
        tick();
        check_grant("hold.first", 4'b0001, 1'b1, 2'd0);
        for (int c = 2; c <= 16; c++) begin
            tick();
            check($sformatf("hold%0d.grant", c), 32'(bus.grant), 32'b0001);
            check($sformatf("hold%0d.timeout", c), 32'(bus.timeout), 32'd0);
        end
`ifdef ARB_TIMEOUT_EN
        tick();
        check("to.pulse", 32'(bus.timeout), 32'd1);
        check_grant("to.rel", 4'b0000, 1'b0, 2'd0);
        tick();
        check("to.clear", 32'(bus.timeout), 32'd0);
        check_grant("to.next", 4'b0010, 1'b1, 2'd1);
`else
        for (int c = 17; c <= 20; c++) begin
            tick();
            check($sformatf("hold%0d.grant", c), 32'(bus.grant), 32'b0001);
            check($sformatf("hold%0d.timeout", c), 32'(bus.timeout), 32'd0);
        end
`endif
        bus.req = 4'b0000;
        tick();
        check_grant("final", 4'b0000, 1'b0, 2'(bus.grant_idx));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
